// File: rtl/lcd_pkg.sv
// PCD8544 command set, panel geometry and arbiter states.
// Shared by the SPI arbiter and its round-robin picker.
package lcd_pkg;

  localparam logic [7:0] FUNC_EXT    = 8'h21;
  localparam logic [7:0] VOP         = 8'h90;
  localparam logic [7:0] FUNC_BASIC  = 8'h20;
  localparam logic [7:0] DISP_NORMAL = 8'h0C;
  localparam logic [7:0] SET_X       = 8'h80;
  localparam logic [7:0] SET_Y       = 8'h40;

  localparam int LCD_COLS  = 84;
  localparam int LCD_BANKS = 6;

  typedef enum logic [2:0] {
    S_INIT,
    S_CLR_X,
    S_CLR_Y,
    S_CLR,
    S_IDLE,
    S_ADDR_X,
    S_ADDR_Y,
    S_DATA
  } state_t;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx
  );
    logic [7:0] c;
    unique case (idx)
      2'd0:    c = FUNC_EXT;
      2'd1:    c = VOP;
      2'd2:    c = FUNC_BASIC;
      default: c = DISP_NORMAL;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] sat_x(
    input logic [6:0] x
  );
    return (x > 7'(LCD_COLS - 1)) ?
      7'(LCD_COLS - 1) : x;
  endfunction

  function automatic logic [2:0] sat_y(
    input logic [2:0] y
  );
    return (y > 3'(LCD_BANKS - 1)) ?
      3'(LCD_BANKS - 1) : y;
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin winner search starting one past the last owner.
// Pure combinational; returns one-hot and binary winner.
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  int j;

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Shares the LCD spi_master byte port between drawing clients;
// runs panel init and clears, then round-robin client bursts.
module lcd_spi_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int STALL_MAX   = 1024,
  parameter int CLEAR_BYTES = 504
) (
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 spi_avail,
  output logic [7:0]           spi_data,
  output logic                 spi_dc,
  output logic                 spi_start,
  input  logic [NUM_REQ-1:0]   cli_req,
  input  logic [7*NUM_REQ-1:0] cli_x,
  input  logic [3*NUM_REQ-1:0] cli_y,
  input  logic [8*NUM_REQ-1:0] cli_data,
  input  logic [NUM_REQ-1:0]   cli_valid,
  input  logic [NUM_REQ-1:0]   cli_last,
  output logic [NUM_REQ-1:0]   cli_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 clear_req,
  output logic                 init_done,
  output logic                 err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STALL_MAX + 1);

  state_t state, state_n;

  logic          live;
  logic [8:0]    cnt;
  logic [SW-1:0] stall;
  logic [IW-1:0] ptr;
  logic [6:0]    x_l;
  logic [2:0]    y_l;
  logic          clr_pend;

  logic [6:0] xs [NUM_REQ];
  logic [2:0] ys [NUM_REQ];
  logic [7:0] ds [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign xs[g] = cli_x[g*7 +: 7];
    assign ys[g] = cli_y[g*3 +: 3];
    assign ds[g] = cli_data[g*8 +: 8];
  end

  logic               win_any;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;

  lcd_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (cli_req),
    .ptr (ptr),
    .any (win_any),
    .win (win_oh),
    .idx (win_idx)
  );

  logic own_valid, own_last;
  logic fire, pend;
  logic take, drop, tmo;
  logic clr_go, clr_done;

  assign own_valid = cli_valid[ptr];
  assign own_last  = cli_last[ptr];
  assign fire      = spi_start & spi_avail;
  assign pend      = clr_pend | clear_req;

  assign cli_ready =
    (state == S_DATA && fire) ? grant : '0;

  // live holds outputs at reset values for one cycle after Reset
  always_comb begin
    spi_data  = '0;
    spi_dc    = 1'b0;
    spi_start = 1'b0;
    if (live) begin
      unique case (state)
        S_INIT: begin
          spi_data  = init_cmd(cnt[1:0]);
          spi_start = 1'b1;
        end
        S_CLR_X: begin
          spi_data  = SET_X;
          spi_start = 1'b1;
        end
        S_CLR_Y: begin
          spi_data  = SET_Y;
          spi_start = 1'b1;
        end
        S_CLR: begin
          spi_dc    = 1'b1;
          spi_start = 1'b1;
        end
        S_ADDR_X: begin
          spi_data  = SET_X | {1'b0, x_l};
          spi_start = 1'b1;
        end
        S_ADDR_Y: begin
          spi_data  = SET_Y | {5'b0, y_l};
          spi_start = 1'b1;
        end
        S_DATA: begin
          spi_data  = ds[ptr];
          spi_dc    = 1'b1;
          spi_start = own_valid;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    take     = 1'b0;
    drop     = 1'b0;
    tmo      = 1'b0;
    clr_go   = 1'b0;
    clr_done = 1'b0;
    unique case (state)
      S_INIT:
        if (fire && cnt == 9'd3) state_n = S_CLR_X;
      S_CLR_X:
        if (fire) state_n = S_CLR_Y;
      S_CLR_Y:
        if (fire) state_n = S_CLR;
      S_CLR:
        if (fire && cnt == 9'(CLEAR_BYTES - 1)) begin
          state_n  = S_IDLE;
          clr_done = 1'b1;
        end
      S_IDLE:
        if (pend) begin
          state_n = S_CLR_X;
          clr_go  = 1'b1;
        end else if (init_done && win_any) begin
          state_n = S_ADDR_X;
          take    = 1'b1;
        end
      S_ADDR_X:
        if (fire) state_n = S_ADDR_Y;
      S_ADDR_Y:
        if (fire) state_n = S_DATA;
      S_DATA:
        if (fire && own_last) begin
          state_n = S_IDLE;
          drop    = 1'b1;
        end else if (!own_valid &&
                     stall == SW'(STALL_MAX - 1)) begin
          state_n = S_IDLE;
          drop    = 1'b1;
          tmo     = 1'b1;
        end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) state <= S_INIT;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      live        <= 1'b0;
      cnt         <= '0;
      stall       <= '0;
      ptr         <= IW'(NUM_REQ - 1);
      grant       <= '0;
      x_l         <= '0;
      y_l         <= '0;
      clr_pend    <= 1'b0;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      live <= 1'b1;
      if (state != state_n) cnt <= '0;
      else if (fire)        cnt <= cnt + 9'd1;
      if (state != S_DATA || own_valid) stall <= '0;
      else stall <= stall + SW'(1);
      if (take) begin
        grant <= win_oh;
        ptr   <= win_idx;
        x_l   <= sat_x(xs[win_idx]);
        y_l   <= sat_y(ys[win_idx]);
      end else if (drop) begin
        grant <= '0;
      end
      // a pulse in the cycle a clear starts is absorbed by it
      if (clr_go)         clr_pend <= 1'b0;
      else if (clear_req) clr_pend <= 1'b1;
      if (clr_done) init_done <= 1'b1;
      err_timeout <= tmo;
    end
  end

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Random-timing bench for lcd_spi_arbiter with a byte-stream
// scoreboard built from the panel/arbitration rules.
module tb_lcd_spi_arbiter;

  localparam int N    = 4;
  localparam int SMAX = 1024;
  localparam int CB   = 504;

  logic           clock = 1'b0;
  logic           Reset;
  logic           spi_avail;
  logic [7:0]     spi_data;
  logic           spi_dc;
  logic           spi_start;
  logic [N-1:0]   cli_req;
  logic [7*N-1:0] cli_x;
  logic [3*N-1:0] cli_y;
  logic [8*N-1:0] cli_data;
  logic [N-1:0]   cli_valid;
  logic [N-1:0]   cli_last;
  logic [N-1:0]   cli_ready;
  logic [N-1:0]   grant;
  logic           clear_req;
  logic           init_done;
  logic           err_timeout;

  always #5 clock = ~clock;

  lcd_spi_arbiter #(
    .NUM_REQ     (N),
    .STALL_MAX   (SMAX),
    .CLEAR_BYTES (CB)
  ) dut (
    .clock       (clock),
    .Reset       (Reset),
    .spi_avail   (spi_avail),
    .spi_data    (spi_data),
    .spi_dc      (spi_dc),
    .spi_start   (spi_start),
    .cli_req     (cli_req),
    .cli_x       (cli_x),
    .cli_y       (cli_y),
    .cli_data    (cli_data),
    .cli_valid   (cli_valid),
    .cli_last    (cli_last),
    .cli_ready   (cli_ready),
    .grant       (grant),
    .clear_req   (clear_req),
    .init_done   (init_done),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic       dc;
    logic [7:0] d;
    int         own;
    int         endk;
  } exp_t;

  exp_t       expq [$];
  logic [8:0] cq [N][$];
  bit         stall_cli [N];
  int         xs [N];
  int         ys [N];

  int total = 0;
  int bad   = 0;

  int m_ptr, tmo_cnt, st_own, hold, gap;
  bit m_pend, m_init, gnt0, done_chk, clr_pulse;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic dc, input logic [7:0] d,
                      input int own, input int endk);
    exp_t e;
    e.dc = dc; e.d = d; e.own = own; e.endk = endk;
    expq.push_back(e);
  endtask

  task automatic push_clear();
    push(1'b0, 8'h80, -1, 0);
    push(1'b0, 8'h40, -1, 0);
    for (int j = 0; j < CB; j++)
      push(1'b1, 8'h00, -1, (j == CB - 1) ? 2 : 0);
  endtask

  function automatic bit any_cq();
    for (int i = 0; i < N; i++)
      if (cq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // next owner: first requester after the previous one, cyclically
  task automatic arbitrate();
    int w;
    int xa, ya;
    logic [8:0] h;
    if (expq.size() != 0 || tmo_cnt != 0) return;
    if (m_pend) begin
      m_pend = 1'b0;
      push_clear();
      return;
    end
    if (!m_init) return;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && cq[(m_ptr + k) % N].size() != 0)
        w = (m_ptr + k) % N;
    if (w < 0) return;
    m_ptr = w;
    xa = (xs[w] > 83) ? 83 : xs[w];
    ya = (ys[w] > 5) ? 5 : ys[w];
    push(1'b0, 8'h80 + 8'(xa), w, 0);
    push(1'b0, 8'h40 + 8'(ya), w, stall_cli[w] ? 3 : 0);
    if (!stall_cli[w]) begin
      for (int j = 0; j < cq[w].size(); j++) begin
        h = cq[w][j];
        push(1'b1, h[7:0], w, h[8] ? 1 : 0);
        if (h[8]) break;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [8:0] h;
    @(negedge clock);
    if (gnt0) begin
      check("gnt_drop", 32'(grant), 0);
      gnt0 = 1'b0;
    end
    if (done_chk) begin
      check("init_done", 32'(init_done), 1);
      done_chk = 1'b0;
    end
    if (tmo_cnt > 0) begin
      tmo_cnt--;
      if (tmo_cnt == 0) begin
        check("tmo_pulse", 32'(err_timeout), 1);
        check("tmo_grant", 32'(grant), 0);
        cq[st_own].delete();
        stall_cli[st_own] = 1'b0;
      end else if (err_timeout) begin
        check("tmo_early", 32'(err_timeout), 0);
      end
    end else if (err_timeout) begin
      check("tmo_extra", 32'(err_timeout), 0);
    end
    for (int i = 0; i < N; i++) begin
      cli_x[i*7 +: 7] = 7'(xs[i]);
      cli_y[i*3 +: 3] = 3'(ys[i]);
      if (cq[i].size() != 0) begin
        h = cq[i][0];
        cli_req[i]        = 1'b1;
        cli_data[i*8 +: 8] = h[7:0];
        cli_last[i]       = h[8];
        cli_valid[i]      = stall_cli[i] ? 1'b0 :
                            ($urandom_range(0, 3) != 0);
      end else begin
        cli_req[i]        = 1'b0;
        cli_data[i*8 +: 8] = 8'($urandom);
        cli_last[i]       = 1'b0;
        cli_valid[i]      = 1'b0;
      end
    end
    clear_req = clr_pulse;
    if (clr_pulse) m_pend = 1'b1;
    clr_pulse = 1'b0;
    #1;
    spi_avail = 1'b0;
    if (spi_start) begin
      hold++;
      if (hold >= gap) begin
        spi_avail = 1'b1;
        hold = 0;
        gap  = $urandom_range(1, 4);
      end
    end else begin
      hold = 0;
    end
    #1;
    if (spi_avail) begin
      if (expq.size() == 0) begin
        check("extra_byte", 32'(spi_start), 0);
      end else begin
        e = expq.pop_front();
        check("dc", 32'(spi_dc), 32'(e.dc));
        check("data", 32'(spi_data), 32'(e.d));
        check("grant", 32'(grant),
              (e.own < 0) ? 0 : (32'd1 << e.own));
        check("ready", 32'(cli_ready),
              (e.dc && e.own >= 0) ? (32'd1 << e.own) : 0);
        if (e.dc && e.own >= 0) void'(cq[e.own].pop_front());
        if (e.endk == 1) gnt0 = 1'b1;
        if (e.endk == 2) begin
          m_init   = 1'b1;
          done_chk = 1'b1;
        end
        if (e.endk == 3) begin
          tmo_cnt = SMAX + 1;
          st_own  = e.own;
        end
      end
    end else if (cli_ready != 0) begin
      check("ready_idle", 32'(cli_ready), 0);
    end
    arbitrate();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((expq.size() != 0 || tmo_cnt != 0 ||
            any_cq() || m_pend) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) check("drain_bound", n, limit - 1);
    repeat (6) tick();
  endtask

  task automatic do_reset();
    logic [7:0] ic [4];
    @(negedge clock);
    Reset     = 1'b1;
    spi_avail = 1'b0;
    clear_req = 1'b0;
    cli_req   = '0;
    cli_valid = '0;
    cli_last  = '0;
    expq.delete();
    for (int i = 0; i < N; i++) begin
      cq[i].delete();
      stall_cli[i] = 1'b0;
    end
    tmo_cnt = 0; gnt0 = 0; done_chk = 0; clr_pulse = 0;
    repeat (2) @(negedge clock);
    check("rst_start", 32'(spi_start), 0);
    check("rst_data", 32'(spi_data), 0);
    check("rst_dc", 32'(spi_dc), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(cli_ready), 0);
    check("rst_init", 32'(init_done), 0);
    check("rst_tmo", 32'(err_timeout), 0);
    Reset  = 1'b0;
    m_ptr  = N - 1;
    m_pend = 1'b0;
    m_init = 1'b0;
    hold   = 0;
    gap    = 4;
    ic = '{8'h21, 8'h90, 8'h20, 8'h0C};
    for (int j = 0; j < 4; j++) push(1'b0, ic[j], -1, 0);
    push_clear();
  endtask

  task automatic add_burst(input int c, input int x,
                           input int y, input int len);
    xs[c] = x;
    ys[c] = y;
    for (int j = 0; j < len; j++)
      cq[c].push_back({(j == len - 1), 8'($urandom)});
  endtask

  initial begin
    Reset = 1'b1;
    cli_x = '0; cli_y = '0; cli_data = '0;
    for (int i = 0; i < N; i++) begin
      xs[i] = 0; ys[i] = 0;
    end
    do_reset();
    drain(20000);

    xs[1] = 5; ys[1] = 2;
    cq[1].push_back({1'b0, 8'hAA});
    cq[1].push_back({1'b0, 8'hBB});
    cq[1].push_back({1'b1, 8'hCC});
    drain(2000);

    for (int r = 0; r < 4; r++) begin
      add_burst(0, 10, 1, 1);
      add_burst(2, 30, 4, 1);
    end
    drain(2000);

    add_burst(3, 100, 7, 3);
    drain(2000);
    add_burst(0, 83, 5, 2);
    drain(2000);
    add_burst(0, 84, 6, 2);
    drain(2000);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) != 0)
          add_burst(i, $urandom_range(0, 127),
                    $urandom_range(0, 7), $urandom_range(1, 4));
      drain(4000);
    end

    stall_cli[2] = 1'b1;
    add_burst(2, 12, 3, 2);
    add_burst(1, 40, 0, 2);
    drain(6000);

    add_burst(0, 7, 2, 6);
    repeat (2) tick();
    clr_pulse = 1'b1;
    repeat (2) tick();
    clr_pulse = 1'b1;
    drain(6000);

    clr_pulse = 1'b1;
    for (int n = 0; n < 4000 && expq.size() > 250; n++)
      tick();
    do_reset();
    drain(20000);

    add_burst(1, 0, 0, 3);
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
